// File: rtl/node_share_sched_pkg.sv
// Shared types and constants for the primitive-recursion node scheduler.
package node_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_RUN    = 3'd2,
    ST_DONE   = 3'd3,
    ST_ABORT  = 3'd4
  } sched_state_t;

  localparam int DEF_WIDTH = 16;
  localparam int TMO_W     = 32;
  // Cycles the node reset is held after a watchdog abort
  localparam int ABORT_LEN = 2;

endpackage

// File: rtl/node_share_sched_if.sv
// Requester bus plus node handshake seen by the scheduler.
interface node_share_sched_if
  import node_sched_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = DEF_WIDTH
);
  logic [N-1:0]       REQ;
  logic [N*WIDTH-1:0] REQ_IN0;
  logic [N*WIDTH-1:0] REQ_IN1;
  logic [N-1:0]       ACK;
  logic               ERR;
  logic [WIDTH-1:0]   RES_OUT;
  logic               BUSY;
  logic               NODE_RST;
  logic               NODE_ST;
  logic [WIDTH-1:0]   NODE_IN0;
  logic [WIDTH-1:0]   NODE_IN1;
  logic               NODE_RD;
  logic [WIDTH-1:0]   NODE_RES;

  modport master (
    output REQ, REQ_IN0, REQ_IN1, NODE_RD, NODE_RES,
    input  ACK, ERR, RES_OUT, BUSY, NODE_RST, NODE_ST, NODE_IN0, NODE_IN1
  );

  modport slave (
    input  REQ, REQ_IN0, REQ_IN1, NODE_RD, NODE_RES,
    output ACK, ERR, RES_OUT, BUSY, NODE_RST, NODE_ST, NODE_IN0, NODE_IN1
  );
endinterface

// File: rtl/node_share_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after start, wrapping.
module node_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] win,
  output logic          vld
);

  // Scan N positions from start; the first hit is kept
  always_comb begin
    int  pos_v;
    logic hit_v;
    win = '0;
    vld = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos_v = ((int'(start) + k) >= N) ? (int'(start) + k - N) : (int'(start) + k);
      hit_v = !vld && req[pos_v];
      win   = hit_v ? IW'(pos_v) : win;
      vld   = vld | hit_v;
    end
  end

endmodule

// File: rtl/node_share_sched.sv
// Shares one recursion node among N requesters: round-robin grant, start/ready
// handshake, result return with one-cycle ACK and a watchdog abort path.
module node_share_sched
  import node_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = 65535
) (
  input  logic              CLK,
  input  logic              RST,
  node_share_sched_if.slave sif
);

  localparam int               IW      = $clog2(N);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
  localparam logic [1:0]       AB_LAST = 2'(ABORT_LEN - 1);

  sched_state_t     state_r, state_nxt_s;
  logic [IW-1:0]    ptr_r, ptr_nxt_s, win_r, win_nxt_s, start_s, pick_s;
  logic             first_r, first_nxt_s, pick_vld_s;
  logic [WIDTH-1:0] in0_r, in0_nxt_s, in1_r, in1_nxt_s, res_r, res_nxt_s;
  logic [TMO_W-1:0] cnt_r, cnt_nxt_s;
  logic [1:0]       ab_cnt_r, ab_nxt_s;
  logic [N-1:0]     ack_r, ack_nxt_s;
  logic             err_r, err_nxt_s, busy_r, busy_nxt_s;
  logic             node_rst_r, nrst_nxt_s, node_st_r, st_nxt_s;

  // The very first search after reset starts at requester 0
  assign start_s = first_r ? '0 : ((ptr_r == IW'(N - 1)) ? '0 : ptr_r + IW'(1));

  node_rr_arbiter #(.N(N)) u_arb (
    .req   (sif.REQ),
    .start (start_s),
    .win   (pick_s),
    .vld   (pick_vld_s)
  );

  // Next-state and next-output decode
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    first_nxt_s = first_r;
    win_nxt_s   = win_r;
    in0_nxt_s   = in0_r;
    in1_nxt_s   = in1_r;
    cnt_nxt_s   = cnt_r;
    ab_nxt_s    = ab_cnt_r;
    ack_nxt_s   = '0;
    err_nxt_s   = 1'b0;
    res_nxt_s   = res_r;
    busy_nxt_s  = busy_r;
    nrst_nxt_s  = 1'b0;
    st_nxt_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_vld_s && sif.NODE_RD) begin
          state_nxt_s = ST_LAUNCH;
          win_nxt_s   = pick_s;
          in0_nxt_s   = sif.REQ_IN0[int'(pick_s)*WIDTH +: WIDTH];
          in1_nxt_s   = sif.REQ_IN1[int'(pick_s)*WIDTH +: WIDTH];
          busy_nxt_s  = 1'b1;
          cnt_nxt_s   = '0;
          st_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (cnt_r == TMO_LIM) begin
          state_nxt_s = ST_ABORT;
          nrst_nxt_s  = 1'b1;
          ab_nxt_s    = 2'd0;
        end else if (!sif.NODE_RD) begin
          state_nxt_s = ST_RUN;
          cnt_nxt_s   = cnt_r + 32'd1;
        end else begin
          st_nxt_s    = 1'b1;
          cnt_nxt_s   = cnt_r + 32'd1;
        end
      end
      ST_RUN: begin
        if (cnt_r == TMO_LIM) begin
          state_nxt_s = ST_ABORT;
          nrst_nxt_s  = 1'b1;
          ab_nxt_s    = 2'd0;
        end else if (sif.NODE_RD) begin
          state_nxt_s       = ST_DONE;
          res_nxt_s         = sif.NODE_RES;
          ack_nxt_s[win_r]  = 1'b1;
        end else begin
          cnt_nxt_s   = cnt_r + 32'd1;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
        ptr_nxt_s   = win_r;
        first_nxt_s = 1'b0;
      end
      ST_ABORT: begin
        if (ab_cnt_r == AB_LAST) begin
          state_nxt_s      = ST_DONE;
          ack_nxt_s[win_r] = 1'b1;
          err_nxt_s        = 1'b1;
          res_nxt_s        = '0;
        end else begin
          nrst_nxt_s  = 1'b1;
          ab_nxt_s    = ab_cnt_r + 2'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, operand, watchdog and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      first_r    <= 1'b1;
      win_r      <= '0;
      in0_r      <= '0;
      in1_r      <= '0;
      cnt_r      <= '0;
      ab_cnt_r   <= 2'd0;
      ack_r      <= '0;
      err_r      <= 1'b0;
      res_r      <= '0;
      busy_r     <= 1'b0;
      node_rst_r <= 1'b1;
      node_st_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      first_r    <= first_nxt_s;
      win_r      <= win_nxt_s;
      in0_r      <= in0_nxt_s;
      in1_r      <= in1_nxt_s;
      cnt_r      <= cnt_nxt_s;
      ab_cnt_r   <= ab_nxt_s;
      ack_r      <= ack_nxt_s;
      err_r      <= err_nxt_s;
      res_r      <= res_nxt_s;
      busy_r     <= busy_nxt_s;
      node_rst_r <= nrst_nxt_s;
      node_st_r  <= st_nxt_s;
    end
  end

  assign sif.ACK      = ack_r;
  assign sif.ERR      = err_r;
  assign sif.RES_OUT  = res_r;
  assign sif.BUSY     = busy_r;
  assign sif.NODE_RST = node_rst_r;
  assign sif.NODE_ST  = node_st_r;
  assign sif.NODE_IN0 = in0_r;
  assign sif.NODE_IN1 = in1_r;

endmodule

// File: doc/node_share_sched.md
# node_share_sched

Scheduler that shares one primitive-recursion node (ST/RD/RES handshake, operands IN0/IN1) between N requesters. It arbitrates round-robin and holds the winner's operands on the node for the whole run. It generates the node's start level, waits for RD to complete a full low-then-high cycle, and returns RES to the winner with a one-cycle acknowledge. A timeout watchdog resets a hung node. The block sits between requester logic and a single instance of a generated node module.

## Interface
- N, default 4: number of requesters (2..8).
- WIDTH, default 16: operand/result width; matches node datapath.
- TIMEOUT, default 65535: max cycles per run before abort; 32-bit counter.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- REQ  in  N  per-requester request level; held until own ACK.
- REQ_IN0  in  N*WIDTH  operand 0, slice i for requester i.
- REQ_IN1  in  N*WIDTH  operand 1 (iteration count), slice i.
- ACK  out  N  one-hot one-cycle completion pulse.
- ERR  out  1  pulses with ACK when run was aborted by timeout.
- RES_OUT  out  WIDTH  result of the last completed run, held until the next ACK.
- BUSY  out  1  high from grant until ACK.
- NODE_RST  out  1  active-high reset to node.
- NODE_ST  out  1  node start level.
- NODE_IN0, NODE_IN1  out  WIDTH  operands to node.
- NODE_RD  in  1  node ready.
- NODE_RES  in  WIDTH  node result.

## Operation
- Reset values: ACK=0, ERR=0, RES_OUT=0, BUSY=0, NODE_ST=0, NODE_IN0/IN1=0, NODE_RST=1 while RST low, RR pointer=0, state IDLE, counter 0.
- FSM states: IDLE, LAUNCH, RUN, DONE, ABORT.
- IDLE: if any REQ is high and NODE_RD=1, latch the winner index. The winner is the first requester at or after pointer+1 (mod N); after reset, search starts at 0. Latch its operands into NODE_IN0/IN1, set BUSY, and go to LAUNCH. Requests are not granted while NODE_RD=0.
- LAUNCH: NODE_ST=1. On NODE_RD=0, drop NODE_ST and go to RUN.
- RUN: NODE_ST=0. On NODE_RD=1, capture NODE_RES into RES_OUT and go to DONE.
- DONE: ACK[winner]=1 for one cycle, clear BUSY, set pointer to the winner, go to IDLE.
- Timeout: the counter clears on grant and increments in LAUNCH/RUN. When it reaches TIMEOUT, go to ABORT.
- ABORT: NODE_RST=1 for exactly 2 cycles, NODE_ST=0, then DONE with ERR=1 and RES_OUT=0.
- Operands stay constant on NODE_IN0/IN1 from grant until the following grant. The node reads them throughout iteration.
- If REQ drops mid-run (protocol violation), the run still completes and ACK still pulses.
- If REQ is still high in the cycle after its ACK, it is a new request.

## Timing
- REQ high in IDLE at edge t: NODE_ST high from t+1.
- The node's internal starter adds latency. LAUNCH waits for RD low with no fixed bound except the timeout.
- NODE_RD high observed at edge r in RUN: RES_OUT valid and ACK high in cycle r+1. IDLE at r+2, so the next NODE_ST is at r+3 at the earliest.
- NODE_RD glitching high during LAUNCH is ignored; only RUN's rising condition completes a run.
- Asynchronous RST low mid-run: all outputs go to reset values immediately, and no ACK is generated for the in-flight request.

## Structure
- Package node_sched_pkg: state enum, default WIDTH, TIMEOUT width constant (32), ABORT reset length (2).
- Sub-module node_rr_arbiter: combinational pick from REQ plus pointer, returning winner index and valid. The FSM, operand registers, watchdog and result register live in node_share_sched.
- The bench uses a behavioural node model: RD drops 2 cycles after ST rises, and RES = IN0 + IN1 after IN1+3 cycles low.

## Test plan
- Single request: REQ[2]=1, IN0=5, IN1=3 -> NODE_ST high next cycle, then ACK[2] pulse with RES_OUT=8, ERR=0, BUSY low after ACK.
- Contention: REQ=4'b1111 from reset -> ACK order 0,1,2,3. Then re-raising REQ[0] and REQ[3] -> order 0,3 (pointer at 3 wraps).
- Back-to-back: REQ[1] held through ACK -> second grant; NODE_ST rises no earlier than 2 cycles after the first ACK; operands unchanged in between.
- Timeout: model never drops RD, TIMEOUT=20 -> NODE_RST high 2 cycles, ACK with ERR=1, RES_OUT=0; the next request completes normally.
- Reset mid-run: RST low during RUN -> ACK never pulses, NODE_RST=1, pointer=0. After release, REQ[3] is served with the correct result.
- IN1=0 (node skips iteration): RES_OUT equals the model's base-case value (IN0); ACK single pulse.
